if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit MIPS16-style core. Holds the PC and issues word-addressed fetches to instruction memory. The instruction SRAM is shared with the MEM stage, so a fetch may wait several cycles for ack. It presents a registered {pc, inst, valid} to the decode stage and honours stall, branch redirect and flush.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_id_reg.sv | 35 +++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, encodings and FSM states for the fetch stage.
// Build option DELAY_SLOT_EN selects delay-slot branch semantics.
package if_stage_pkg;

  localparam int IF_ADDR_W = 16;
  localparam int IF_INST_W = 16;

  localparam logic [15:0] IF_RESET_PC = 16'h0000;
  localparam logic [15:0] IF_NOP_INST = 16'h0800;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register with load, bubble and hold controls.
// Synchronous active-high reset empties the register to a NOP bubble.
module if_id_reg import if_stage_pkg::*; #(
  parameter int AW = IF_ADDR_W,
  parameter int IW = IF_INST_W,
  parameter logic [IW-1:0] NOP = IF_NOP_INST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_bubble,
  input  logic [AW-1:0] i_pc,
  input  logic [IW-1:0] i_inst,
  output logic [AW-1:0] o_pc,
  output logic [IW-1:0] o_inst,
  output logic          o_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc    <= '0;
      o_inst  <= NOP;
      o_valid <= INVALID;
    end else if (i_load) begin
      o_pc    <= i_pc;
      o_inst  <= i_inst;
      o_valid <= VALID;
    end else if (i_bubble) begin
      // Bubble keeps the old PC so pc_o stays meaningful.
      o_inst  <= NOP;
      o_valid <= INVALID;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC, fetch FSM and IF/ID register for the 16-bit core.
// Define DELAY_SLOT_EN to deliver the instruction after a taken branch.
module if_stage import if_stage_pkg::*; #(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int INST_W = IF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              imem_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_hold_pc;
  logic [INST_W-1:0]   r_hold_inst;
  logic                w_req;
  logic                w_ack;
  logic                w_br;
  logic                w_load;
  logic                w_bubble;
  logic [ADDR_W-1:0]   w_ld_pc;
  logic [INST_W-1:0]   w_ld_inst;
  logic [ADDR_W-1:0]   w_pc_next;

`ifdef DELAY_SLOT_EN
  logic                r_pend;
  logic [ADDR_W-1:0]   r_tgt;
  assign w_pc_next = r_pend ? r_tgt : r_pc + ADDR_W'(1);
`else
  assign w_pc_next = r_pc + ADDR_W'(1);
`endif

  // Request drops during reset/flush so a pending fetch restarts cleanly.
  assign w_req = !rst && !flush_i && (r_state == S_FETCH);
  assign w_ack = w_req && imem_ack_i;
  assign w_br  = branch_en_i && !stall_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;

  always_comb begin
    w_load    = 1'b0;
    w_bubble  = 1'b0;
    w_ld_pc   = r_pc;
    w_ld_inst = imem_rdata_i;
    if (flush_i) begin
      w_bubble = 1'b1;
    end else if (r_state == S_HOLD) begin
      if (!stall_i) begin
        w_load    = 1'b1;
        w_ld_pc   = r_hold_pc;
        w_ld_inst = r_hold_inst;
`ifndef DELAY_SLOT_EN
        if (branch_en_i) begin
          w_load   = 1'b0;
          w_bubble = 1'b1;
        end
`endif
      end
    end else if (w_br) begin
`ifdef DELAY_SLOT_EN
      w_load   = w_ack;
      w_bubble = !w_ack;
`else
      w_bubble = 1'b1;
`endif
    end else if (!stall_i) begin
      w_load   = w_ack;
      w_bubble = !w_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
`ifdef DELAY_SLOT_EN
      r_pend      <= 1'b0;
      r_tgt       <= '0;
`endif
    end else if (flush_i) begin
      r_state     <= S_FETCH;
      r_pc        <= flush_pc_i;
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
`ifdef DELAY_SLOT_EN
      r_pend      <= 1'b0;
`endif
    end else if (r_state == S_HOLD) begin
      if (!stall_i) begin
        r_state <= S_FETCH;
        if (branch_en_i) r_pc <= branch_target_i;
      end
    end else if (w_br) begin
`ifdef DELAY_SLOT_EN
      if (w_ack) begin
        r_pc   <= branch_target_i;
        r_pend <= 1'b0;
      end else begin
        r_tgt  <= branch_target_i;
        r_pend <= 1'b1;
      end
`else
      r_pc <= branch_target_i;
`endif
    end else if (w_ack) begin
      r_pc <= w_pc_next;
`ifdef DELAY_SLOT_EN
      r_pend <= 1'b0;
`endif
      if (stall_i) begin
        r_state     <= S_HOLD;
        r_hold_pc   <= r_pc;
        r_hold_inst <= imem_rdata_i;
      end
    end
  end

  if_id_reg #(
    .AW  (ADDR_W),
    .IW  (INST_W),
    .NOP (NOP_INST)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_pc     (w_ld_pc),
    .i_inst   (w_ld_inst),
    .o_pc     (pc_o),
    .o_inst   (inst_o),
    .o_valid  (valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns 16'h1000 + address.
// Expectations switch on DELAY_SLOT_EN where branch behaviour differs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [15:0] flush_pc_i;
  logic        branch_en_i;
  logic [15:0] branch_target_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] imem_rdata_i;
  logic        imem_ack_i;
  logic [15:0] pc_o;
  logic [15:0] inst_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = 16'h1000 + imem_addr_o;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_en_i     (branch_en_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_ack_i      (imem_ack_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_if(string nm, logic [15:0] epc,
                        logic [15:0] einst, logic ev);
    total++;
    if (inst_o !== einst || valid_o !== ev || pc_o !== epc) begin
      bad++;
      $display("FAIL %s: got pc=%h inst=%h v=%b want pc=%h inst=%h v=%b",
               nm, pc_o, inst_o, valid_o, epc, einst, ev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    branch_en_i = 1'b0; branch_target_i = '0; imem_ack_i = 1'b1;
    tick(); tick();
    total++;
    if (pc_o !== 16'h0 || inst_o !== 16'h0800 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ifid: got pc=%h inst=%h v=%b want 0000 0800 0",
               pc_o, inst_o, valid_o);
    end
    total++;
    if (imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_req: got %b want 0", imem_req_o);
    end
    rst = 1'b0; settle();
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset_fetch: got req=%b addr=%h want 1 0000",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_seq();
    imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("seq", 16'(i), 16'h1000 + 16'(i), 1'b1);
    end
  endtask

  task automatic test_wait();
    tick(); tick();
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (imem_addr_o !== 16'h0005 || imem_req_o !== 1'b1) begin
        bad++;
        $display("FAIL wait_addr: got req=%b addr=%h want 1 0005",
                 imem_req_o, imem_addr_o);
      end
      tick();
      chk_if("wait_bubble", 16'h0004, 16'h0800, 1'b0);
    end
    imem_ack_i = 1'b1;
    tick();
    chk_if("wait_ack", 16'h0005, 16'h1005, 1'b1);
  endtask

  task automatic test_stall();
    tick(); tick();
    stall_i = 1'b1; settle();
    total++;
    if (imem_addr_o !== 16'h0008 || imem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_addr: got req=%b addr=%h want 1 0008",
               imem_req_o, imem_addr_o);
    end
    tick();
    chk_if("stall_first", 16'h0007, 16'h1007, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_req: got %b want 0", imem_req_o);
      end
      tick();
      chk_if("stall_hold", 16'h0007, 16'h1007, 1'b1);
    end
    stall_i = 1'b0;
    tick();
    chk_if("stall_release", 16'h0008, 16'h1008, 1'b1);
    total++;
    if (imem_addr_o !== 16'h0009 || imem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_next: got req=%b addr=%h want 1 0009",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 7; i++) tick();
    branch_en_i = 1'b1; branch_target_i = 16'h0040; settle();
    total++;
    if (imem_addr_o !== 16'h0010) begin
      bad++;
      $display("FAIL br_addr: got %h want 0010", imem_addr_o);
    end
    tick();
    branch_en_i = 1'b0;
`ifdef DELAY_SLOT_EN
    chk_if("br_slot", 16'h0010, 16'h1010, 1'b1);
`else
    chk_if("br_bubble", 16'h000F, 16'h0800, 1'b0);
`endif
    settle();
    total++;
    if (imem_addr_o !== 16'h0040) begin
      bad++;
      $display("FAIL br_target: got %h want 0040", imem_addr_o);
    end
    tick();
    chk_if("br_first", 16'h0040, 16'h1040, 1'b1);
  endtask

  task automatic test_branch_wait();
    branch_en_i = 1'b1; branch_target_i = 16'h0040; imem_ack_i = 1'b0;
    tick();
    branch_en_i = 1'b0;
    chk_if("brw_bubble", 16'h0040, 16'h0800, 1'b0);
    settle();
    total++;
`ifdef DELAY_SLOT_EN
    if (imem_addr_o !== 16'h0041) begin
      bad++;
      $display("FAIL brw_wait_addr: got %h want 0041", imem_addr_o);
    end
`else
    if (imem_addr_o !== 16'h0040) begin
      bad++;
      $display("FAIL brw_wait_addr: got %h want 0040", imem_addr_o);
    end
`endif
    tick();
    imem_ack_i = 1'b1;
    tick();
`ifdef DELAY_SLOT_EN
    chk_if("brw_slot", 16'h0041, 16'h1041, 1'b1);
    tick();
    chk_if("brw_target", 16'h0040, 16'h1040, 1'b1);
`else
    chk_if("brw_target", 16'h0040, 16'h1040, 1'b1);
    tick();
    chk_if("brw_next", 16'h0041, 16'h1041, 1'b1);
`endif
  endtask

  task automatic test_flush();
    stall_i = 1'b1;
    tick();
    flush_i = 1'b1; flush_pc_i = 16'h0004; settle();
    total++;
    if (imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_req: got %b want 0", imem_req_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || inst_o !== 16'h0800) begin
      bad++;
      $display("FAIL flush_bubble: got inst=%h v=%b want 0800 0",
               inst_o, valid_o);
    end
    flush_i = 1'b0; stall_i = 1'b0; settle();
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0004) begin
      bad++;
      $display("FAIL flush_restart: got req=%b addr=%h want 1 0004",
               imem_req_o, imem_addr_o);
    end
    tick();
    chk_if("flush_fetch", 16'h0004, 16'h1004, 1'b1);
  endtask

  task automatic test_wrap();
    flush_i = 1'b1; flush_pc_i = 16'hFFFF;
    tick();
    flush_i = 1'b0; settle();
    total++;
    if (imem_addr_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_addr: got %h want ffff", imem_addr_o);
    end
    tick();
    chk_if("wrap_last", 16'hFFFF, 16'h0FFF, 1'b1);
    total++;
    if (imem_addr_o !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_next: got %h want 0000", imem_addr_o);
    end
    tick();
    chk_if("wrap_zero", 16'h0000, 16'h1000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_seq();
    test_wait();
    test_stall();
    test_branch();
    test_branch_wait();
    test_flush();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
